// File: rtl/rf_link_pkg.sv
//==============================================================================
// Module      : rf_link_pkg
// Description : Shared constants for the RF link controller: state_module bit
//               indices, operating-mode codes, FSM encoding and a helper that
//               maps an FSM state onto the one-hot state_module vector.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package rf_link_pkg;

  // Bit positions inside the one-hot state_module output
  localparam int STM_IDLE    = 3;
  localparam int STM_WTRANS  = 2;
  localparam int STM_WRECV   = 1;
  localparam int STM_PROGRAM = 0;

  // Operating modes selected by {M1,M0}
  localparam logic [1:0] MODE_NORMAL    = 2'd0;
  localparam logic [1:0] MODE_WAKEUP    = 2'd1;
  localparam logic [1:0] MODE_POWERSAVE = 2'd2;
  localparam logic [1:0] MODE_PROGRAM   = 2'd3;

  // Controller FSM; SWITCH has no bit in state_module (reads as all zeros)
  typedef enum logic [2:0] {
    ST_SWITCH  = 3'd0,
    ST_IDLE    = 3'd1,
    ST_WTRANS  = 3'd2,
    ST_WRECV   = 3'd3,
    ST_PROGRAM = 3'd4
  } rf_state_e;

  function automatic logic [3:0] state_onehot(input rf_state_e s);
    logic [3:0] oh;
    oh = 4'b0000;
    case (s)
      ST_IDLE:    oh[STM_IDLE]    = 1'b1;
      ST_WTRANS:  oh[STM_WTRANS]  = 1'b1;
      ST_WRECV:   oh[STM_WRECV]   = 1'b1;
      ST_PROGRAM: oh[STM_PROGRAM] = 1'b1;
      default:    oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rf_link_fifo.sv
//==============================================================================
// Module      : rf_link_fifo
// Description : Synchronous first-word-fall-through FIFO. The head entry is
//               visible on rd_data_o with no read latency. Pointers carry one
//               extra wrap bit so full and empty are distinguished without a
//               separate counter. DEPTH must be a power of two, at least 2.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rf_link_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 512
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr_i,
  input  logic                        wr_en_i,
  input  logic [DATA_WIDTH-1:0]       wr_data_i,
  input  logic                        rd_en_i,
  output logic [DATA_WIDTH-1:0]       rd_data_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [$clog2(DEPTH):0]      level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]           wr_ptr_q;
  logic [AW:0]           rd_ptr_q;
  logic                  w_wr;
  logic                  w_rd;

  // A write into a full FIFO and a read from an empty one are ignored
  assign w_wr = wr_en_i && !full_o;
  assign w_rd = rd_en_i && !empty_o;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o   = wr_ptr_q - rd_ptr_q;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; clear has priority over any concurrent push or pop
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (w_wr) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (w_rd) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage array; contents need no reset because the pointers gate visibility
  always_ff @(posedge clk) begin
    if (w_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

`default_nettype wire

// File: rtl/rf_link_controller.sv
//==============================================================================
// Module      : rf_link_controller
// Description : Link controller between the MCU UART and the RF node UART.
//               Buffers MCU bytes and bursts them to the node (threshold or
//               gap flush), forwards node bytes to the MCU, taps MCU bytes as
//               commands in program mode, and drives AUX around mode changes.
// Options     : RF_LINK_STATS_EN adds 16-bit saturating byte/drop counters.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rf_link_controller
  import rf_link_pkg::*;
#(
  parameter int         DATA_WIDTH         = 8,
  parameter int         BUF_DEPTH          = 512,
  parameter int         START_THRESHOLD    = 58,
  parameter int         GAP_CYCLES         = 651,
  parameter int         MODE_SWITCH_CYCLES = 15000,
  parameter logic [1:0] DEFAULT_MODE       = 2'd0
) (
  input  logic                          internal_clk,
  input  logic                          rst,
  input  logic                          M0,
  input  logic                          M1,
  input  logic [DATA_WIDTH-1:0]         mcu_rx_data,
  input  logic                          mcu_rx_valid,
  output logic [DATA_WIDTH-1:0]         node_tx_data,
  output logic                          node_tx_valid,
  input  logic                          node_tx_ready,
  input  logic [DATA_WIDTH-1:0]         node_rx_data,
  input  logic                          node_rx_valid,
  output logic [DATA_WIDTH-1:0]         mcu_tx_data,
  output logic                          mcu_tx_valid,
  input  logic                          mcu_tx_idle,
  output logic [DATA_WIDTH-1:0]         prog_data,
  output logic                          prog_valid,
  output logic                          AUX,
  output logic [1:0]                    mode_sync,
  output logic [3:0]                    state_module,
  output logic [$clog2(BUF_DEPTH):0]    buf_level
`ifdef RF_LINK_STATS_EN
  ,
  output logic [15:0]                   stat_tx_bytes,
  output logic [15:0]                   stat_rx_bytes,
  output logic [15:0]                   stat_drops
`endif
);

  localparam int LVL_W = $clog2(BUF_DEPTH) + 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int SW_W  = $clog2(MODE_SWITCH_CYCLES + 1);

  rf_state_e             state_q, state_d;
  logic [1:0]            m_meta_q, m_sync_q;
  logic [1:0]            mode_q, mode_d;
  logic [SW_W-1:0]       sw_timer_q, sw_timer_d;
  logic [GAP_W-1:0]      gap_tx_q, gap_tx_d;
  logic [GAP_W-1:0]      gap_rx_q, gap_rx_d;
  logic                  aux_q, aux_d;
  logic                  mcu_tx_valid_q;
  logic [DATA_WIDTH-1:0] mcu_tx_data_q;
  logic                  prog_valid_q;
  logic [DATA_WIDTH-1:0] prog_data_q;

  logic                  w_full, w_empty;
  logic [LVL_W-1:0]      w_level, w_level_eff;
  logic                  w_wr_req, w_wr_acc, w_pop, w_clr;
  logic                  w_rx_fwd, w_mode_chg, w_hs_pending;
  logic                  w_gap_tx_done, w_gap_rx_done;

  // MCU bytes are only buffered in the transparent modes (0/1)
  assign w_wr_req  = mcu_rx_valid && (state_q != ST_PROGRAM) &&
                     ((mode_q == MODE_NORMAL) || (mode_q == MODE_WAKEUP));
  assign w_wr_acc  = w_wr_req && !w_full;
  assign w_pop     = node_tx_valid && node_tx_ready;
  assign w_rx_fwd  = node_rx_valid && (mode_q != MODE_PROGRAM) &&
                     ((state_q == ST_IDLE) || (state_q == ST_WRECV));

  // Level including the write landing this cycle, so the burst starts right
  // after the threshold-reaching byte rather than one cycle later
  assign w_level_eff   = w_level + LVL_W'(w_wr_acc);
  assign w_gap_tx_done = (gap_tx_q == GAP_W'(GAP_CYCLES));
  assign w_gap_rx_done = (gap_rx_q == GAP_W'(GAP_CYCLES));
  assign w_mode_chg    = (m_sync_q != mode_q);
  assign w_hs_pending  = node_tx_valid && !node_tx_ready;

  assign node_tx_valid = (state_q == ST_WTRANS) && !w_empty;
  assign mcu_tx_valid  = mcu_tx_valid_q;
  assign mcu_tx_data   = mcu_tx_data_q;
  assign prog_valid    = prog_valid_q;
  assign prog_data     = prog_data_q;
  assign AUX           = aux_q;
  assign mode_sync     = m_sync_q;
  assign state_module  = state_onehot(state_q);
  assign buf_level     = w_level;

  rf_link_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_fifo (
    .clk       (internal_clk),
    .rst       (rst),
    .clr_i     (w_clr),
    .wr_en_i   (w_wr_req),
    .wr_data_i (mcu_rx_data),
    .rd_en_i   (w_pop),
    .rd_data_o (node_tx_data),
    .full_o    (w_full),
    .empty_o   (w_empty),
    .level_o   (w_level)
  );

  // Two-flop synchroniser for the asynchronous mode pins
  always_ff @(posedge internal_clk) begin
    if (rst) begin
      m_meta_q <= DEFAULT_MODE;
      m_sync_q <= DEFAULT_MODE;
    end else begin
      m_meta_q <= {M1, M0};
      m_sync_q <= m_meta_q;
    end
  end

  // Next-state, mode tracking, timers and AUX
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    sw_timer_d = sw_timer_q;
    w_clr      = 1'b0;

    gap_tx_d = mcu_rx_valid ? '0 : (w_gap_tx_done ? gap_tx_q : gap_tx_q + GAP_W'(1));
    gap_rx_d = node_rx_valid ? '0 : (w_gap_rx_done ? gap_rx_q : gap_rx_q + GAP_W'(1));

    if (state_q == ST_SWITCH) begin
      if (w_mode_chg) begin
        // Pins moved again while switching: restart the hold for the new mode
        mode_d     = m_sync_q;
        sw_timer_d = SW_W'(MODE_SWITCH_CYCLES);
      end else if (sw_timer_q != '0) begin
        sw_timer_d = sw_timer_q - SW_W'(1);
      end else if (mcu_tx_idle) begin
        if (mode_q == MODE_PROGRAM) begin
          state_d = ST_PROGRAM;
          w_clr   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
    end else if (w_mode_chg && !w_hs_pending) begin
      // A stalled node handshake must finish before the mode may change
      state_d    = ST_SWITCH;
      mode_d     = m_sync_q;
      sw_timer_d = SW_W'(MODE_SWITCH_CYCLES);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (node_rx_valid) begin
            state_d = ST_WRECV;
          end else if ((w_level_eff >= LVL_W'(START_THRESHOLD)) ||
                       ((w_level != '0) && w_gap_tx_done)) begin
            state_d = ST_WTRANS;
          end
        end
        ST_WTRANS: begin
          if (w_empty) state_d = ST_IDLE;
        end
        ST_WRECV: begin
          if (w_gap_rx_done && mcu_tx_idle) state_d = ST_IDLE;
        end
        ST_PROGRAM: state_d = ST_PROGRAM;
        default:    state_d = ST_SWITCH;
      endcase
    end

    if (state_q == ST_PROGRAM) aux_d = mcu_tx_idle;
    else                       aux_d = (state_q == ST_IDLE) && w_empty && mcu_tx_idle;
  end

  // Controller state registers
  always_ff @(posedge internal_clk) begin
    if (rst) begin
      state_q    <= ST_SWITCH;
      mode_q     <= DEFAULT_MODE;
      sw_timer_q <= SW_W'(MODE_SWITCH_CYCLES);
      gap_tx_q   <= '0;
      gap_rx_q   <= '0;
      aux_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      sw_timer_q <= sw_timer_d;
      gap_tx_q   <= gap_tx_d;
      gap_rx_q   <= gap_rx_d;
      aux_q      <= aux_d;
    end
  end

  // One-cycle forwarding of node bytes to the MCU and MCU bytes to the command tap
  always_ff @(posedge internal_clk) begin
    if (rst) begin
      mcu_tx_valid_q <= 1'b0;
      mcu_tx_data_q  <= '0;
      prog_valid_q   <= 1'b0;
      prog_data_q    <= '0;
    end else begin
      mcu_tx_valid_q <= w_rx_fwd;
      if (w_rx_fwd) mcu_tx_data_q <= node_rx_data;
      prog_valid_q   <= mcu_rx_valid && (state_q == ST_PROGRAM);
      if (mcu_rx_valid && (state_q == ST_PROGRAM)) prog_data_q <= mcu_rx_data;
    end
  end

`ifdef RF_LINK_STATS_EN
  logic [15:0] stat_tx_q, stat_rx_q, stat_drop_q;
  logic        w_drop;

  assign w_drop        = w_wr_req && w_full;
  assign stat_tx_bytes = stat_tx_q;
  assign stat_rx_bytes = stat_rx_q;
  assign stat_drops    = stat_drop_q;

  // Saturating traffic and drop counters
  always_ff @(posedge internal_clk) begin
    if (rst) begin
      stat_tx_q   <= '0;
      stat_rx_q   <= '0;
      stat_drop_q <= '0;
    end else begin
      if (w_pop    && (stat_tx_q   != 16'hFFFF)) stat_tx_q   <= stat_tx_q   + 16'd1;
      if (w_rx_fwd && (stat_rx_q   != 16'hFFFF)) stat_rx_q   <= stat_rx_q   + 16'd1;
      if (w_drop   && (stat_drop_q != 16'hFFFF)) stat_drop_q <= stat_drop_q + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rf_link_controller.sv
//==============================================================================
// Module      : tb_rf_link_controller
// Description : Directed self-checking bench for rf_link_controller using small
//               parameters (depth 64, threshold 58, gap 20, switch hold 40).
//               Optional RF_LINK_STATS_EN adds a drop-counter check.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rf_link_controller;

  localparam int DW    = 8;
  localparam int DEPTH = 64;
  localparam int THR   = 58;
  localparam int GAP   = 20;
  localparam int MSW   = 40;

  logic          clk = 1'b0;
  logic          rst, M0, M1;
  logic [DW-1:0] mcu_rx_data, node_rx_data;
  logic          mcu_rx_valid, node_rx_valid, node_tx_ready, mcu_tx_idle;
  logic [DW-1:0] node_tx_data, mcu_tx_data, prog_data;
  logic          node_tx_valid, mcu_tx_valid, prog_valid, AUX;
  logic [1:0]    mode_sync;
  logic [3:0]    state_module;
  logic [6:0]    buf_level;
`ifdef RF_LINK_STATS_EN
  logic [15:0]   stat_tx_bytes, stat_rx_bytes, stat_drops;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q [$];

  always #5 clk = ~clk;

  rf_link_controller #(
    .DATA_WIDTH (DW), .BUF_DEPTH (DEPTH), .START_THRESHOLD (THR),
    .GAP_CYCLES (GAP), .MODE_SWITCH_CYCLES (MSW), .DEFAULT_MODE (2'd0)
  ) dut (
    .internal_clk (clk),           .rst           (rst),
    .M0           (M0),            .M1            (M1),
    .mcu_rx_data  (mcu_rx_data),   .mcu_rx_valid  (mcu_rx_valid),
    .node_tx_data (node_tx_data),  .node_tx_valid (node_tx_valid),
    .node_tx_ready(node_tx_ready), .node_rx_data  (node_rx_data),
    .node_rx_valid(node_rx_valid), .mcu_tx_data   (mcu_tx_data),
    .mcu_tx_valid (mcu_tx_valid),  .mcu_tx_idle   (mcu_tx_idle),
    .prog_data    (prog_data),     .prog_valid    (prog_valid),
    .AUX          (AUX),           .mode_sync     (mode_sync),
    .state_module (state_module),  .buf_level     (buf_level)
`ifdef RF_LINK_STATS_EN
    ,
    .stat_tx_bytes(stat_tx_bytes), .stat_rx_bytes (stat_rx_bytes),
    .stat_drops   (stat_drops)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs set after this are applied at the next edge
  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pop n bytes from the node port and compare against the expected queue
  task automatic drain(input int n, input bit toggle, input string tag);
    int got;
    got = 0;
    for (int c = 0; c < 600 && got < n; c++) begin
      @(posedge clk);
      #1;
      node_tx_ready = toggle ? ~node_tx_ready : 1'b1;
      #1;
      if (node_tx_valid && node_tx_ready) begin
        check(tag, node_tx_data, exp_q.pop_front());
        got++;
      end
    end
    check({tag, "_count"}, got, n);
  endtask

  initial begin
    int cnt;
    rst = 1'b1; M0 = 1'b0; M1 = 1'b0;
    mcu_rx_data = '0; mcu_rx_valid = 1'b0; node_tx_ready = 1'b0;
    node_rx_data = '0; node_rx_valid = 1'b0; mcu_tx_idle = 1'b1;

    // 1: reset values, AUX low for the switch hold, then IDLE
    step(3);
    check("rst_aux", AUX, 0);
    check("rst_state", state_module, 4'b0000);
    check("rst_level", buf_level, 0);
    check("rst_mode", mode_sync, 2'd0);
    check("rst_valids", {node_tx_valid, mcu_tx_valid, prog_valid}, 3'b000);
    rst = 1'b0;
    step(MSW - 1);
    check("sw_hold_aux", AUX, 0);
    check("sw_hold_state", state_module, 4'b0000);
    step(3);
    check("sw_done_aux", AUX, 1);
    check("sw_done_state", state_module, 4'b1000);

    // 2: threshold burst with 50% ready
    for (int i = 0; i < THR; i++) begin
      mcu_rx_data = DW'(i); mcu_rx_valid = 1'b1;
      exp_q.push_back(DW'(i));
      step();
      if (i == THR - 2) begin
        check("thr_minus1_state", state_module, 4'b1000);
        check("thr_minus1_level", buf_level, THR - 1);
      end
    end
    mcu_rx_valid = 1'b0;
    check("thr_state", state_module, 4'b0100);
    check("thr_level", buf_level, THR);
    drain(THR, 1'b1, "burst_data");
    step(); node_tx_ready = 1'b0; step(3);
    check("burst_end_state", state_module, 4'b1000);
    check("burst_end_aux", AUX, 1);

    // 3: partial packet flushed by the gap timer
    for (int i = 0; i < 5; i++) begin
      mcu_rx_data = DW'(8'h10 + i); mcu_rx_valid = 1'b1;
      exp_q.push_back(DW'(8'h10 + i));
      step();
    end
    mcu_rx_valid = 1'b0;
    cnt = 0;
    while (state_module != 4'b0100 && cnt < 200) begin
      step(); cnt++;
    end
    check("gap_flush_delay", cnt, GAP + 1);
    drain(5, 1'b0, "gap_data");
    step(); node_tx_ready = 1'b0; step(3);
    check("gap_end_level", buf_level, 0);
    check("gap_end_state", state_module, 4'b1000);

    // 4: node bytes forwarded to the MCU, WRECV held by gap and mcu_tx_idle
    node_rx_data = 8'hA5; node_rx_valid = 1'b1; step(); node_rx_valid = 1'b0;
    check("rx1_state", state_module, 4'b0010);
    check("rx1_valid", mcu_tx_valid, 1);
    check("rx1_data", mcu_tx_data, 8'hA5);
    step();
    check("rx1_strobe_end", mcu_tx_valid, 0);
    step();
    node_rx_data = 8'h5A; node_rx_valid = 1'b1; step(); node_rx_valid = 1'b0;
    check("rx2_valid", mcu_tx_valid, 1);
    check("rx2_data", mcu_tx_data, 8'h5A);
    step(GAP - 2);
    check("rx_gap_hold", state_module, 4'b0010);
    mcu_tx_idle = 1'b0; step(5);
    check("rx_busy_hold", state_module, 4'b0010);
    mcu_tx_idle = 1'b1; step();
    check("rx_end_state", state_module, 4'b1000);

    // 5: overfill with the node stalled; three writes dropped
    for (int i = 0; i < DEPTH + 3; i++) begin
      mcu_rx_data = DW'(i) ^ 8'h3C; mcu_rx_valid = 1'b1;
      if (i < DEPTH) exp_q.push_back(DW'(i) ^ 8'h3C);
      step();
    end
    mcu_rx_valid = 1'b0;
    check("full_level", buf_level, DEPTH);
    check("full_valid", node_tx_valid, 1);
    check("full_head", node_tx_data, 8'h3C);
`ifdef RF_LINK_STATS_EN
    check("full_drops", stat_drops, 3);
`endif
    drain(DEPTH, 1'b0, "full_data");
    step(); node_tx_ready = 1'b0; step(3);
    check("full_end_level", buf_level, 0);

    // 6: mode change to program mid-burst waits for the stalled handshake
    exp_q.delete();
    for (int i = 0; i < THR; i++) begin
      mcu_rx_data = DW'(8'h80 + i); mcu_rx_valid = 1'b1; step();
    end
    mcu_rx_valid = 1'b0;
    M0 = 1'b1; M1 = 1'b1;
    step(6);
    check("pend_state", state_module, 4'b0100);
    check("pend_mode", mode_sync, 2'd3);
    node_tx_ready = 1'b1; step(); node_tx_ready = 1'b0;
    check("sw_entry_state", state_module, 4'b0000);
    check("sw_entry_level", buf_level, THR - 1);
    step(MSW + 3);
    check("prog_state", state_module, 4'b0001);
    check("prog_level", buf_level, 0);
    check("prog_aux", AUX, 1);
    check("prog_node_valid", node_tx_valid, 0);
    mcu_rx_data = 8'hC1; mcu_rx_valid = 1'b1; step(); mcu_rx_valid = 1'b0;
    check("prog_valid", prog_valid, 1);
    check("prog_data", prog_data, 8'hC1);
    node_rx_data = 8'h77; node_rx_valid = 1'b1; step(); node_rx_valid = 1'b0;
    check("prog_strobe_end", prog_valid, 0);
    check("prog_rx_gated", mcu_tx_valid, 0);

    // Reset in the middle of operation
    rst = 1'b1; step(); rst = 1'b0;
    check("rst2_state", state_module, 4'b0000);
    check("rst2_aux", AUX, 0);
    check("rst2_prog", prog_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
